// File: rtl/lb_pkg.sv
// Shared types and defaults for the load balancer / region dispatcher pair.
// Both blocks derive the load counter width from the same helper.
package lb_pkg;

    localparam int DEF_N_REGIONS         = 4;
    localparam int DEF_HTTP_META_WIDTH   = 98;
    localparam int DEF_OPERATOR_ID_WIDTH = 16;
    localparam int DEF_QDEPTH            = 16;

    function automatic int load_bits(input int qdepth);
        return $clog2(qdepth);
    endfunction

    localparam int DEF_LOAD_BITS = load_bits(DEF_QDEPTH);

    // All-ones operator id marks a region that has never been configured.
    localparam logic [DEF_OPERATOR_ID_WIDTH-1:0] OID_NONE = '1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DRAIN,
        PR_WAIT,
        DISPATCH
    } disp_state_t;

    typedef struct packed {
        logic [DEF_OPERATOR_ID_WIDTH-1:0] oid;
        logic [DEF_LOAD_BITS-1:0]         load;
    } region_stat_t;

endpackage

// File: rtl/region_credit_counter.sv
// Outstanding-request counter for one region: saturates at QDEPTH-1, never
// drops below zero, and flags a completion that arrives with nothing in flight.
module region_credit_counter
    import lb_pkg::*;
#(
    parameter int QDEPTH    = DEF_QDEPTH,
    parameter int LOAD_BITS = load_bits(QDEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_inc,
    input  logic                 i_dec,
    output logic [LOAD_BITS-1:0] o_load,
    output logic                 o_full,
    output logic                 o_underflow
);

    localparam logic [LOAD_BITS-1:0] MAX_LOAD = LOAD_BITS'(QDEPTH - 1);

    logic [LOAD_BITS-1:0] r_load;

    // A simultaneous inc and dec falls through both branches: net unchanged.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_load <= '0;
        end else if (i_inc && !i_dec && (r_load != MAX_LOAD)) begin
            r_load <= r_load + 1'b1;
        end else if (i_dec && !i_inc && (r_load != '0)) begin
            r_load <= r_load - 1'b1;
        end
    end

    assign o_load      = r_load;
    assign o_full      = (r_load == MAX_LOAD);
    assign o_underflow = i_dec & ~i_inc & (r_load == '0);

endmodule

// File: rtl/region_dispatcher.sv
// Routes each balanced request to its region, reconfiguring the region first
// when it runs a different operator, and publishes per-region {oid, load}.
module region_dispatcher
    import lb_pkg::*;
#(
    parameter  int N_REGIONS         = DEF_N_REGIONS,
    parameter  int HTTP_META_WIDTH   = DEF_HTTP_META_WIDTH,
    parameter  int OPERATOR_ID_WIDTH = DEF_OPERATOR_ID_WIDTH,
    parameter  int QDEPTH            = DEF_QDEPTH,
    localparam int LOAD_BITS         = load_bits(QDEPTH),
    localparam int SEL_W             = $clog2(N_REGIONS),
    localparam int STAT_W            = OPERATOR_ID_WIDTH + LOAD_BITS
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          req_tvalid,
    output logic                          req_tready,
    input  logic [HTTP_META_WIDTH-1:0]    req_tdata,
    input  logic [SEL_W-1:0]              lb_sel,
    output logic                          disp_tvalid,
    input  logic [N_REGIONS-1:0]          disp_tready,
    output logic [SEL_W-1:0]              disp_tdest,
    output logic [HTTP_META_WIDTH-1:0]    disp_tdata,
    input  logic [N_REGIONS-1:0]          done_valid,
    output logic                          pr_req,
    output logic [SEL_W-1:0]              pr_region,
    output logic [OPERATOR_ID_WIDTH-1:0]  pr_oid,
    input  logic                          pr_done,
    output logic [N_REGIONS*STAT_W-1:0]   region_stats_out,
    output logic                          err_underflow
);

    disp_state_t                  r_state;
    disp_state_t                  w_state_nxt;
    logic                         r_run;
    logic [HTTP_META_WIDTH-1:0]   r_req_q;
    logic [SEL_W-1:0]             r_sel_q;
    logic                         r_err_underflow;
    logic [OPERATOR_ID_WIDTH-1:0] r_region_oid [N_REGIONS];
    logic [N_REGIONS*STAT_W-1:0]  r_stats;

    logic [SEL_W-1:0]             w_sel_in;
    logic [OPERATOR_ID_WIDTH-1:0] w_oid_q;
    logic                         w_req_hs;
    logic                         w_disp_hs;
    logic                         w_oid_match;
    logic [LOAD_BITS-1:0]         w_load [N_REGIONS];
    logic [N_REGIONS-1:0]         w_full;
    logic [N_REGIONS-1:0]         w_underflow;
    logic [N_REGIONS-1:0]         w_inc;

    generate
        if ((1 << SEL_W) != N_REGIONS) begin : g_clamp
            assign w_sel_in = (lb_sel > SEL_W'(N_REGIONS - 1)) ? SEL_W'(N_REGIONS - 1) : lb_sel;
        end else begin : g_no_clamp
            assign w_sel_in = lb_sel;
        end
    endgenerate

    assign w_oid_q     = r_req_q[OPERATOR_ID_WIDTH-1:0];
    assign w_oid_match = (r_region_oid[r_sel_q] == w_oid_q);
    assign req_tready  = r_run & (r_state == IDLE);
    assign w_req_hs    = req_tvalid & req_tready;
    assign disp_tvalid = (r_state == DISPATCH);
    assign disp_tdest  = r_sel_q;
    assign disp_tdata  = r_req_q;
    assign w_disp_hs   = disp_tvalid & disp_tready[r_sel_q];
    assign pr_req      = (r_state == PR_WAIT);
    assign pr_region   = r_sel_q;
    assign pr_oid      = w_oid_q;

    generate
        for (genvar g = 0; g < N_REGIONS; g++) begin : g_region
            assign w_inc[g] = w_disp_hs && (r_sel_q == SEL_W'(g));

            region_credit_counter #(
                .QDEPTH    (QDEPTH),
                .LOAD_BITS (LOAD_BITS)
            ) u_credit (
                .i_clk       (aclk),
                .i_rst_n     (aresetn),
                .i_inc       (w_inc[g]),
                .i_dec       (done_valid[g]),
                .o_load      (w_load[g]),
                .o_full      (w_full[g]),
                .o_underflow (w_underflow[g])
            );
        end
    endgenerate

    // NOTE: next state defaults to the current state first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:     if (w_req_hs) w_state_nxt = CHECK;
            CHECK: begin
                if (!w_oid_match)          w_state_nxt = DRAIN;
                else if (!w_full[r_sel_q]) w_state_nxt = DISPATCH;
            end
            DRAIN:    if (w_load[r_sel_q] == '0) w_state_nxt = PR_WAIT;
            PR_WAIT:  if (pr_done) w_state_nxt = DISPATCH;
            DISPATCH: if (w_disp_hs) w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state         <= IDLE;
            r_run           <= 1'b0;
            r_req_q         <= '0;
            r_sel_q         <= '0;
            r_err_underflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
            if (w_req_hs) begin
                r_req_q <= req_tdata;
                r_sel_q <= w_sel_in;
            end
            if (|w_underflow) r_err_underflow <= 1'b1;
        end
    end

    // NOTE: this small array is reset on purpose; every region must read as
    // unconfigured after reset, and an abandoned PR leaves no trace here.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int r = 0; r < N_REGIONS; r++) r_region_oid[r] <= '1;
        end else if ((r_state == PR_WAIT) && pr_done) begin
            r_region_oid[r_sel_q] <= w_oid_q;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int r = 0; r < N_REGIONS; r++)
                r_stats[r*STAT_W +: STAT_W] <= {{OPERATOR_ID_WIDTH{1'b1}}, {LOAD_BITS{1'b0}}};
        end else begin
            for (int r = 0; r < N_REGIONS; r++)
                r_stats[r*STAT_W +: STAT_W] <= {r_region_oid[r], w_load[r]};
        end
    end

    assign region_stats_out = r_stats;
    assign err_underflow    = r_err_underflow;

endmodule

// File: tb/tb_region_dispatcher.sv
// Directed scenarios for region_dispatcher: PR on mismatch, fast path, full
// stall, drain-before-PR, simultaneous inc/dec, underflow and mid-PR reset.
module tb_region_dispatcher;
    import lb_pkg::*;

    localparam int NR  = 4;
    localparam int MW  = 98;
    localparam int OW  = 16;
    localparam int QD  = 16;
    localparam int SW  = 2;
    localparam int STW = 20;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              req_tvalid = 1'b0;
    logic              req_tready;
    logic [MW-1:0]     req_tdata = '0;
    logic [SW-1:0]     lb_sel = '0;
    logic              disp_tvalid;
    logic [NR-1:0]     disp_tready = '0;
    logic [SW-1:0]     disp_tdest;
    logic [MW-1:0]     disp_tdata;
    logic [NR-1:0]     done_valid = '0;
    logic              pr_req;
    logic [SW-1:0]     pr_region;
    logic [OW-1:0]     pr_oid;
    logic              pr_done = 1'b0;
    logic [NR*STW-1:0] region_stats_out;
    logic              err_underflow;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    region_dispatcher #(
        .N_REGIONS(NR), .HTTP_META_WIDTH(MW), .OPERATOR_ID_WIDTH(OW), .QDEPTH(QD)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tdata(req_tdata), .lb_sel(lb_sel),
        .disp_tvalid(disp_tvalid), .disp_tready(disp_tready), .disp_tdest(disp_tdest), .disp_tdata(disp_tdata),
        .done_valid(done_valid),
        .pr_req(pr_req), .pr_region(pr_region), .pr_oid(pr_oid), .pr_done(pr_done),
        .region_stats_out(region_stats_out), .err_underflow(err_underflow)
    );

    function automatic region_stat_t stat_of(input int r);
        return region_stat_t'(region_stats_out[r*STW +: STW]);
    endfunction

    function automatic logic [MW-1:0] mk_meta(input logic [OW-1:0] oid, input logic [7:0] tag);
        logic [MW-1:0] m;
        m = '0;
        m[OW-1:0]   = oid;
        m[MW-1 -: 8] = tag;
        m[40 +: 8]  = ~tag;
        return m;
    endfunction

    task automatic tick();
        @(negedge aclk);
    endtask

    task automatic pulse_done(input logic [NR-1:0] m);
        done_valid = m;
        tick();
        done_valid = '0;
    endtask

    // Returns at the falling edge right after the accepting clock edge.
    task automatic send_req(input logic [OW-1:0] oid, input logic [SW-1:0] sel,
                            input logic [7:0] tag, output bit ok);
        ok = 1'b0;
        req_tdata  = mk_meta(oid, tag);
        lb_sel     = sel;
        req_tvalid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (req_tready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        req_tvalid = 1'b0;
    endtask

    task automatic wait_for_pr(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (pr_req) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_for_disp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (disp_tvalid) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    // Full request with automatic PR completion and an always-ready region.
    task automatic do_request(input logic [OW-1:0] oid, input logic [SW-1:0] sel,
                              input logic [7:0] tag, output bit ok);
        bit acc;
        ok = 1'b0;
        disp_tready = '1;
        send_req(oid, sel, tag, acc);
        if (acc) begin
            for (int i = 0; i < 100; i++) begin
                pr_done = pr_req;
                if (disp_tvalid) begin tick(); ok = 1'b1; break; end
                tick();
            end
        end
        pr_done = 1'b0;
    endtask

    task automatic test_reset();
        region_stat_t s;
        repeat (2) tick();
        checks++; if (req_tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %0b want 0", req_tready); end
        checks++; if (disp_tvalid !== 1'b0) begin errors++; $display("FAIL rst_disp_tvalid: got %0b want 0", disp_tvalid); end
        checks++; if (pr_req !== 1'b0) begin errors++; $display("FAIL rst_pr_req: got %0b want 0", pr_req); end
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b want 0", err_underflow); end
        for (int r = 0; r < NR; r++) begin
            s = stat_of(r);
            checks++;
            if (s.oid !== 16'hFFFF || s.load !== 4'd0) begin
                errors++; $display("FAIL rst_stats%0d: got oid=%h load=%0d want oid=ffff load=0", r, s.oid, s.load);
            end
        end
        aresetn = 1'b1;
        checks++; if (req_tready !== 1'b0) begin errors++; $display("FAIL rst_tready_release: got %0b want 0", req_tready); end
        tick();
        checks++; if (req_tready !== 1'b1) begin errors++; $display("FAIL rst_tready_run: got %0b want 1", req_tready); end
    endtask

    task automatic test_pr_first();
        bit ok;
        region_stat_t s;
        disp_tready = '0;
        send_req(16'd5, 2'd2, 8'h11, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL pr1_accept: got %0b want 1", ok); end
        checks++; if (pr_req !== 1'b0) begin errors++; $display("FAIL pr1_early_req: got %0b want 0", pr_req); end
        wait_for_pr(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL pr1_req_timeout: got %0b want 1", ok); end
        checks++; if (pr_region !== 2'd2 || pr_oid !== 16'd5) begin
            errors++; $display("FAIL pr1_fields: got region=%0d oid=%0d want region=2 oid=5", pr_region, pr_oid); end
        repeat (4) tick();
        checks++; if (pr_req !== 1'b1 || disp_tvalid !== 1'b0 || pr_oid !== 16'd5) begin
            errors++; $display("FAIL pr1_hold: got pr_req=%0b disp=%0b oid=%0d want 1 0 5", pr_req, disp_tvalid, pr_oid); end
        pr_done = 1'b1;
        tick();
        pr_done = 1'b0;
        checks++; if (disp_tvalid !== 1'b1 || disp_tdest !== 2'd2 || pr_req !== 1'b0) begin
            errors++; $display("FAIL pr1_dispatch: got disp=%0b dest=%0d pr_req=%0b want 1 2 0", disp_tvalid, disp_tdest, pr_req); end
        checks++; if (disp_tdata !== mk_meta(16'd5, 8'h11)) begin
            errors++; $display("FAIL pr1_tdata: got %h want %h", disp_tdata, mk_meta(16'd5, 8'h11)); end
        disp_tready = 4'b0100;
        tick();
        disp_tready = '0;
        checks++; if (disp_tvalid !== 1'b0) begin errors++; $display("FAIL pr1_hs: got %0b want 0", disp_tvalid); end
        tick();
        s = stat_of(2);
        checks++; if (s.oid !== 16'd5 || s.load !== 4'd1) begin
            errors++; $display("FAIL pr1_stats: got oid=%0d load=%0d want 5 1", s.oid, s.load); end
    endtask

    task automatic test_fast_path();
        bit ok;
        region_stat_t s;
        disp_tready = 4'b0100;
        send_req(16'd5, 2'd2, 8'h22, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL fast_accept: got %0b want 1", ok); end
        checks++; if (disp_tvalid !== 1'b0) begin errors++; $display("FAIL fast_n1: got %0b want 0", disp_tvalid); end
        tick();
        checks++; if (disp_tvalid !== 1'b1 || pr_req !== 1'b0 || disp_tdest !== 2'd2) begin
            errors++; $display("FAIL fast_n2: got disp=%0b pr=%0b dest=%0d want 1 0 2", disp_tvalid, pr_req, disp_tdest); end
        checks++; if (disp_tdata !== mk_meta(16'd5, 8'h22)) begin
            errors++; $display("FAIL fast_tdata: got %h want %h", disp_tdata, mk_meta(16'd5, 8'h22)); end
        tick();
        checks++; if (disp_tvalid !== 1'b0 || req_tready !== 1'b1) begin
            errors++; $display("FAIL fast_n3: got disp=%0b tready=%0b want 0 1", disp_tvalid, req_tready); end
        tick();
        s = stat_of(2);
        checks++; if (s.oid !== 16'd5 || s.load !== 4'd2) begin
            errors++; $display("FAIL fast_stats: got oid=%0d load=%0d want 5 2", s.oid, s.load); end
        disp_tready = '0;
    endtask

    task automatic test_full_stall();
        bit ok;
        bit all_ok;
        region_stat_t s;
        all_ok = 1'b1;
        for (int i = 0; i < QD - 1; i++) begin
            do_request(16'd3, 2'd1, 8'(i), ok);
            all_ok &= ok;
        end
        checks++; if (all_ok !== 1'b1) begin errors++; $display("FAIL full_fill: got %0b want 1", all_ok); end
        tick();
        s = stat_of(1);
        checks++; if (s.oid !== 16'd3 || s.load !== 4'd15) begin
            errors++; $display("FAIL full_stats: got oid=%0d load=%0d want 3 15", s.oid, s.load); end
        disp_tready = '1;
        send_req(16'd3, 2'd1, 8'h33, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL full_accept16: got %0b want 1", ok); end
        repeat (5) tick();
        checks++; if (disp_tvalid !== 1'b0 || req_tready !== 1'b0) begin
            errors++; $display("FAIL full_stall: got disp=%0b tready=%0b want 0 0", disp_tvalid, req_tready); end
        pulse_done(4'b0010);
        wait_for_disp(ok);
        checks++; if (ok !== 1'b1 || disp_tdest !== 2'd1) begin
            errors++; $display("FAIL full_release: got ok=%0b dest=%0d want 1 1", ok, disp_tdest); end
        s = stat_of(1);
        checks++; if (s.load !== 4'd14) begin errors++; $display("FAIL full_freed: got load=%0d want 14", s.load); end
        tick();
        tick();
        s = stat_of(1);
        checks++; if (s.load !== 4'd15) begin errors++; $display("FAIL full_refill: got load=%0d want 15", s.load); end
    endtask

    task automatic test_drain();
        bit ok;
        bit ok2;
        region_stat_t s;
        do_request(16'd3, 2'd0, 8'h40, ok);
        do_request(16'd3, 2'd0, 8'h41, ok2);
        checks++; if ((ok & ok2) !== 1'b1) begin errors++; $display("FAIL drain_setup: got %0b want 1", ok & ok2); end
        send_req(16'd7, 2'd0, 8'h44, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL drain_accept: got %0b want 1", ok); end
        repeat (4) tick();
        checks++; if (pr_req !== 1'b0 || disp_tvalid !== 1'b0) begin
            errors++; $display("FAIL drain_load2: got pr=%0b disp=%0b want 0 0", pr_req, disp_tvalid); end
        pulse_done(4'b0001);
        repeat (2) tick();
        checks++; if (pr_req !== 1'b0) begin errors++; $display("FAIL drain_load1: got %0b want 0", pr_req); end
        pulse_done(4'b0001);
        wait_for_pr(ok);
        checks++; if (ok !== 1'b1 || pr_region !== 2'd0 || pr_oid !== 16'd7) begin
            errors++; $display("FAIL drain_pr: got ok=%0b region=%0d oid=%0d want 1 0 7", ok, pr_region, pr_oid); end
        s = stat_of(0);
        checks++; if (s.oid !== 16'd3 || s.load !== 4'd0) begin
            errors++; $display("FAIL drain_pre_oid: got oid=%0d load=%0d want 3 0", s.oid, s.load); end
        pr_done = 1'b1;
        tick();
        pr_done = 1'b0;
        wait_for_disp(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL drain_disp: got %0b want 1", ok); end
        tick();
        tick();
        s = stat_of(0);
        checks++; if (s.oid !== 16'd7 || s.load !== 4'd1) begin
            errors++; $display("FAIL drain_post: got oid=%0d load=%0d want 7 1", s.oid, s.load); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        region_stat_t s;
        do_request(16'd9, 2'd3, 8'h50, ok);
        disp_tready = '0;
        send_req(16'd9, 2'd3, 8'h55, ok);
        wait_for_disp(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL simul_disp: got %0b want 1", ok); end
        disp_tready = 4'b1000;
        done_valid  = 4'b1000;
        tick();
        disp_tready = '0;
        done_valid  = '0;
        checks++; if (disp_tvalid !== 1'b0) begin errors++; $display("FAIL simul_hs: got %0b want 0", disp_tvalid); end
        tick();
        s = stat_of(3);
        checks++; if (s.oid !== 16'd9 || s.load !== 4'd1) begin
            errors++; $display("FAIL simul_load: got oid=%0d load=%0d want 9 1", s.oid, s.load); end
        done_valid = 4'b0100;
        tick();
        tick();
        done_valid = '0;
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL uf_early: got %0b want 0", err_underflow); end
        pulse_done(4'b0100);
        checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_flag: got %0b want 1", err_underflow); end
        tick();
        s = stat_of(2);
        checks++; if (s.oid !== 16'd5 || s.load !== 4'd0) begin
            errors++; $display("FAIL uf_load: got oid=%0d load=%0d want 5 0", s.oid, s.load); end
    endtask

    task automatic test_reset_mid_pr();
        bit ok;
        region_stat_t s;
        pulse_done(4'b0001);
        disp_tready = '0;
        send_req(16'd8, 2'd0, 8'h66, ok);
        wait_for_pr(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL midpr_req: got %0b want 1", ok); end
        #2 aresetn = 1'b0;
        #1;
        s = stat_of(1);
        checks++; if (pr_req !== 1'b0 || req_tready !== 1'b0) begin
            errors++; $display("FAIL midpr_async: got pr=%0b tready=%0b want 0 0", pr_req, req_tready); end
        checks++; if (s.load !== 4'd0 || err_underflow !== 1'b0) begin
            errors++; $display("FAIL midpr_clear: got load1=%0d err=%0b want 0 0", s.load, err_underflow); end
        tick();
        aresetn = 1'b1;
        checks++; if (req_tready !== 1'b0) begin errors++; $display("FAIL midpr_release: got %0b want 0", req_tready); end
        tick();
        checks++; if (req_tready !== 1'b1) begin errors++; $display("FAIL midpr_run: got %0b want 1", req_tready); end
        for (int r = 0; r < NR; r++) begin
            s = stat_of(r);
            checks++;
            if (s.oid !== OID_NONE || s.load !== 4'd0) begin
                errors++; $display("FAIL midpr_stats%0d: got oid=%h load=%0d want ffff 0", r, s.oid, s.load);
            end
        end
        pr_done = 1'b1;
        tick();
        pr_done = 1'b0;
        tick();
        checks++; if (pr_req !== 1'b0 || disp_tvalid !== 1'b0 || req_tready !== 1'b1) begin
            errors++; $display("FAIL stray_pr_done: got pr=%0b disp=%0b tready=%0b want 0 0 1", pr_req, disp_tvalid, req_tready); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_pr_first();
        test_fast_path();
        test_full_stall();
        test_drain();
        test_back_to_back();
        test_reset_mid_pr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/region_dispatcher.md
Name: region_dispatcher

Overview:
- Sits downstream of loadbalancer. Accepts each HTTP meta request together with the region index the balancer chose.
- Guarantees the chosen region runs the requested operator: drains the region and triggers partial reconfiguration (PR) on an operator mismatch.
- Forwards the request to the region, tracks per-region outstanding load, and publishes the per-region {oid, load} stats word the balancer consumes.

Parameters:
- N_REGIONS, 4, number of reconfigurable regions
- HTTP_META_WIDTH, 98, meta word width; oid is in bits [OPERATOR_ID_WIDTH-1:0]
- OPERATOR_ID_WIDTH, 16, operator id width; all-ones = "unconfigured"
- QDEPTH, 16, region queue depth; max outstanding per region = QDEPTH-1
- LOAD_BITS, $clog2(QDEPTH), load counter width (derived)

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- req_tvalid  in  1  request valid
- req_tready  out  1  request ready
- req_tdata  in  HTTP_META_WIDTH  meta word
- lb_sel  in  $clog2(N_REGIONS)  region chosen by balancer; sampled with the req handshake
- disp_tvalid  out  1  dispatch valid
- disp_tready  in  N_REGIONS  per-region ready; only bit disp_tdest is used
- disp_tdest  out  $clog2(N_REGIONS)  target region
- disp_tdata  out  HTTP_META_WIDTH  forwarded meta word
- done_valid  in  N_REGIONS  per-region completion pulse, one request per bit per cycle
- pr_req  out  1  PR request, level, held until pr_done
- pr_region  out  $clog2(N_REGIONS)  region to reconfigure
- pr_oid  out  OPERATOR_ID_WIDTH  operator to load
- pr_done  in  1  PR complete pulse
- region_stats_out  out  N_REGIONS*(OPERATOR_ID_WIDTH+LOAD_BITS)  region r at slice r: {oid, load}, load in LSBs
- err_underflow  out  1  sticky: done_valid arrived while load==0

Behaviour:
- Reset (async, aresetn=0): state IDLE; all loads 0; all region oids all-ones; run flag 0; disp_tvalid 0; pr_req 0; err_underflow 0; req_tready 0. The run flag sets on the first aclk edge after release.
- req_tready = run & (state==IDLE). A handshake latches req_tdata and lb_sel into req_q/sel_q, then goes to CHECK.
- CHECK: oid_q = req_q oid.
  - If region_oid[sel_q]==oid_q and load[sel_q]<QDEPTH-1: go to DISPATCH.
  - If region_oid[sel_q]==oid_q and load[sel_q]==QDEPTH-1: stay in CHECK until a completion frees a slot.
  - If the oids differ: go to DRAIN.
- DRAIN: wait until load[sel_q]==0 (can be the same cycle as entry), then go to PR_WAIT and assert pr_req with pr_region=sel_q and pr_oid=oid_q.
- PR_WAIT: hold pr_req and its fields stable. On pr_done: region_oid[sel_q]<=oid_q, pr_req<=0, go to DISPATCH. A pr_done outside PR_WAIT is ignored.
- DISPATCH: disp_tvalid=1, disp_tdest=sel_q, disp_tdata=req_q, all stable until disp_tready[sel_q]. On that handshake load[sel_q]++ and go to IDLE.
- Best-case latency: accept at cycle N; disp_tvalid visible at cycle N+2; next accept at N+3 at the earliest.
- Load update per region each cycle: +1 on dispatch handshake, -1 on done_valid.
  - Both in the same cycle: net unchanged.
  - done_valid while load==0 and no same-cycle dispatch: load stays 0, err_underflow<=1.
  - Load never exceeds QDEPTH-1; no wrap.
- Completions on other regions continue in every state.
- region_stats_out is registered and reflects load/oid as of the previous cycle (1-cycle lag).
- Reset mid-PR or mid-dispatch drops the in-flight request and deasserts pr_req immediately. The PR controller must tolerate an abandoned request.
- lb_sel >= N_REGIONS (non-power-of-2 N) is clamped to N_REGIONS-1.

Decomposition:
- Shared package lb_pkg:
  - disp_state_t enum {IDLE, CHECK, DRAIN, PR_WAIT, DISPATCH}
  - region_stat_t packed struct {oid, load}
  - OID_NONE constant (all-ones)
  - LOAD_BITS derivation, shared with loadbalancer
- Sub-module region_credit_counter: one per region via generate.
  - Inputs: inc, dec. Outputs: load, full (load==QDEPTH-1), underflow pulse.
  - Implements the simultaneous-inc/dec and saturation rules.

Test Plan:
- After reset, oid 5 request to region 2 -> DRAIN then pr_req with pr_region=2, pr_oid=5. pr_done at +4 -> disp_tvalid, disp_tdest=2. Stats slice 2 = {5,1}.
- Second oid 5 request to region 2 with disp_tready[2]=1 -> no pr_req; disp_tvalid exactly 2 cycles after accept; load 2.
- Fill region 1 (oid 3) to 15 loads, then send a 16th -> stall in CHECK, req_tready=0. One done_valid[1] -> dispatch, load returns to 15.
- Region 0 oid 3 with load 2, request oid 7 -> pr_req held 0 until two done_valid[0] pulses, then asserted; oid updated to 7 after pr_done.
- Region 3 load 1, done_valid[3] in the same cycle as the dispatch handshake to 3 -> load stays 1. done_valid[2] at load 0 -> err_underflow=1, load 0.
- aresetn=0 during PR_WAIT -> pr_req=0 and loads 0 immediately. After release, req_tready rises one cycle later and all oids read all-ones.
